// File: rtl/coredata_bram_bridge.sv
// Pipelined bridge from a req/gnt/rvalid core data port to a single-port, byte-writable BRAM.
// Each request travels as a token next to the BRAM read latency, so every response comes back in order.
module coredata_bram_bridge #(
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    ADDR_WIDTH      = 32,
   parameter int                    BRAM_AW         = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int                    RD_LATENCY      = 1,
   parameter int                    MAX_OUTSTANDING = 2,
   parameter int                    REG_OUT         = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o,
   output logic                    bram_en,
   output logic [DATA_WIDTH/8-1:0] bram_we,
   output logic [BRAM_AW-1:0]      bram_addr,
   output logic [DATA_WIDTH-1:0]   bram_dout,
   input  logic [DATA_WIDTH-1:0]   bram_din
);

   localparam int BE_W    = DATA_WIDTH / 8;
   localparam int BYTE_SH = $clog2(BE_W);
   localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1) + 1;

   logic [ADDR_WIDTH-1:0] offset_p0;
   logic [ADDR_WIDTH-1:0] word_off_p0;
   logic                  in_win_p0;
   logic                  acc_p0;

   logic [RD_LATENCY-1:0] vld_pipe;
   logic [RD_LATENCY-1:0] rd_pipe;
   logic [RD_LATENCY-1:0] err_pipe;

   logic                  rsp_vld;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_data;

   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_live;

   // ---- stage p0: acceptance, window decode, BRAM drive ----
   // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
   assign offset_p0   = addr_i - BASE_ADDR;
   assign word_off_p0 = offset_p0 >> BYTE_SH;
   assign in_win_p0   = (word_off_p0 >> BRAM_AW) == '0;

   // A response retiring this cycle frees its slot immediately, which keeps
   // MAX_OUTSTANDING == RD_LATENCY at full throughput.
   assign cnt_live = cnt_q - CNT_W'(rvalid_o);
   assign gnt_o    = req_i & ~rst_i & (cnt_live < CNT_W'(MAX_OUTSTANDING));
   assign acc_p0   = req_i & gnt_o;

   assign bram_en   = acc_p0 & in_win_p0;
   assign bram_we   = (bram_en & we_i) ? be_i : '0;
   assign bram_addr = word_off_p0[BRAM_AW-1:0];
   assign bram_dout = wdata_i;

   // ---- stages 1..RD_LATENCY: token shift register, never stalls ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_pipe <= '0;
         rd_pipe  <= '0;
         err_pipe <= '0;
      end else begin
         vld_pipe[0] <= acc_p0;
         rd_pipe[0]  <= acc_p0 & ~we_i;
         err_pipe[0] <= acc_p0 & ~in_win_p0;
         for (int s = 1; s < RD_LATENCY; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            rd_pipe[s]  <= rd_pipe[s-1];
            err_pipe[s] <= err_pipe[s-1];
         end
      end
   end

   assign rsp_vld  = vld_pipe[RD_LATENCY-1];
   assign rsp_err  = err_pipe[RD_LATENCY-1];
   assign rsp_data = (rd_pipe[RD_LATENCY-1] & ~rsp_err) ? bram_din : '0;

   // ---- optional output stage ----
   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic                  rvalid_q;
         logic                  err_q;
         logic [DATA_WIDTH-1:0] rdata_q;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               rvalid_q <= 1'b0;
               err_q    <= 1'b0;
               rdata_q  <= '0;
            end else begin
               rvalid_q <= rsp_vld;
               err_q    <= rsp_vld & rsp_err;
               rdata_q  <= rsp_data;
            end
         end

         assign rvalid_o = rvalid_q;
         assign err_o    = err_q;
         assign rdata_o  = rdata_q;
      end else begin : g_comb_out
         assign rvalid_o = rsp_vld;
         assign err_o    = rsp_vld & rsp_err;
         assign rdata_o  = rsp_data;
      end
   endgenerate

   // Outstanding count retires on the visible rvalid_o, after any output stage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (acc_p0 && !rvalid_o) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else if (!acc_p0 && rvalid_o) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_coredata_bram_bridge.sv
// Directed bench for coredata_bram_bridge: four instances in different configurations,
// each attached to a small behavioural BRAM with a matching read latency.
module tb_coredata_bram_bridge;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic preload = 1'b1;

   logic        req   [4];
   logic        gnt   [4];
   logic [31:0] addr  [4];
   logic        we    [4];
   logic [3:0]  be    [4];
   logic [31:0] wdata [4];
   logic        rvalid[4];
   logic [31:0] rdata [4];
   logic        err   [4];
   logic        en    [4];
   logic [3:0]  bwe   [4];
   logic [11:0] baddr [4];
   logic [31:0] bdout [4];
   logic [31:0] din   [4];

   logic [31:0] mem [4][16];
   logic [31:0] dl  [4][8];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // inst 0: latency 1, inst 1: latency 3 at base 0x4000_0000,
   // inst 2: latency 4 / 3 outstanding, inst 3: registered outputs latency 2
   coredata_bram_bridge #(.RD_LATENCY(1), .MAX_OUTSTANDING(2), .REG_OUT(0)) u_a (
      .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
      .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
      .bram_en(en[0]), .bram_we(bwe[0]), .bram_addr(baddr[0]), .bram_dout(bdout[0]), .bram_din(din[0]));

   coredata_bram_bridge #(.BASE_ADDR(32'h4000_0000), .RD_LATENCY(3), .MAX_OUTSTANDING(2), .REG_OUT(0)) u_b (
      .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
      .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
      .bram_en(en[1]), .bram_we(bwe[1]), .bram_addr(baddr[1]), .bram_dout(bdout[1]), .bram_din(din[1]));

   coredata_bram_bridge #(.RD_LATENCY(4), .MAX_OUTSTANDING(3), .REG_OUT(0)) u_c (
      .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
      .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]),
      .bram_en(en[2]), .bram_we(bwe[2]), .bram_addr(baddr[2]), .bram_dout(bdout[2]), .bram_din(din[2]));

   coredata_bram_bridge #(.RD_LATENCY(2), .MAX_OUTSTANDING(3), .REG_OUT(1)) u_d (
      .clk_i(clk), .rst_i(rst), .req_i(req[3]), .gnt_o(gnt[3]), .addr_i(addr[3]), .we_i(we[3]),
      .be_i(be[3]), .wdata_i(wdata[3]), .rvalid_o(rvalid[3]), .rdata_o(rdata[3]), .err_o(err[3]),
      .bram_en(en[3]), .bram_we(bwe[3]), .bram_addr(baddr[3]), .bram_dout(bdout[3]), .bram_din(din[3]));

   function automatic logic [31:0] init_word(input int w);
      case (w)
         2:       return 32'hAAAA_AAAA;
         4:       return 32'hDEAD_BEEF;
         default: return 32'h1111_0000 + 32'(w);
      endcase
   endfunction

   // Behavioural BRAMs: 16 words each, output delayed to the instance's read latency.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (preload) begin
            for (int w = 0; w < 16; w++) mem[i][w] <= init_word(w);
         end else if (en[i]) begin
            for (int b = 0; b < 4; b++)
               if (bwe[i][b]) mem[i][baddr[i][3:0]][8*b +: 8] <= bdout[i][8*b +: 8];
         end
         if (en[i]) dl[i][0] <= mem[i][baddr[i][3:0]];
         for (int k = 1; k < 8; k++) dl[i][k] <= dl[i][k-1];
      end
   end

   assign din[0] = dl[0][0];
   assign din[1] = dl[1][2];
   assign din[2] = dl[2][3];
   assign din[3] = dl[3][1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic r, input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d);
      req[i] = r; addr[i] = a; we[i] = w; be[i] = b; wdata[i] = d;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) drive(i, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

      // reset state, with a request pending on inst 0 and 3
      tick; tick;
      drive(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
      drive(3, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
      #1;
      chk("rst_gnt",    32'(gnt[0]),    32'h0);
      chk("rst_en",     32'(en[0]),     32'h0);
      chk("rst_we",     32'(bwe[0]),    32'h0);
      chk("rst_rvalid", 32'(rvalid[0]), 32'h0);
      chk("rst_err",    32'(err[0]),    32'h0);
      chk("rst_rdata",  rdata[0],       32'h0);
      chk("rst_gnt_d",  32'(gnt[3]),    32'h0);
      chk("rst_rdata_d", rdata[3],      32'h0);
      tick;
      rst = 1'b0; preload = 1'b0;
      drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      drive(3, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

      // single read of 0x10, latency 1
      tick; drive(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0); #1;
      chk("t1_gnt",  32'(gnt[0]),    32'h1);
      chk("t1_en",   32'(en[0]),     32'h1);
      chk("t1_addr", 32'(baddr[0]),  32'h4);
      chk("t1_we",   32'(bwe[0]),    32'h0);
      chk("t1_rv0",  32'(rvalid[0]), 32'h0);
      tick; drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0); #1;
      chk("t1_rv",    32'(rvalid[0]), 32'h1);
      chk("t1_rdata", rdata[0],       32'hDEAD_BEEF);
      chk("t1_err",   32'(err[0]),    32'h0);

      // partial write then read-back of the same word
      tick; drive(0, 1'b1, 32'h8, 1'b1, 4'b0011, 32'h1234_5678); #1;
      chk("t2_wgnt",  32'(gnt[0]),   32'h1);
      chk("t2_wen",   32'(en[0]),    32'h1);
      chk("t2_we",    32'(bwe[0]),   32'h3);
      chk("t2_waddr", 32'(baddr[0]), 32'h2);
      chk("t2_wdout", bdout[0],      32'h1234_5678);
      tick; drive(0, 1'b1, 32'h8, 1'b0, 4'hF, 32'h0); #1;
      chk("t2_rgnt",   32'(gnt[0]),    32'h1);
      chk("t2_rwe",    32'(bwe[0]),    32'h0);
      chk("t2_wrv",    32'(rvalid[0]), 32'h1);
      chk("t2_wrdata", rdata[0],       32'h0);
      chk("t2_werr",   32'(err[0]),    32'h0);
      tick; drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0); #1;
      chk("t2_rrv",    32'(rvalid[0]), 32'h1);
      chk("t2_rrdata", rdata[0],       32'hAAAA_5678);

      // latency 3, two outstanding: req held for four reads
      tick; drive(1, 1'b1, 32'h4000_0004, 1'b0, 4'h0, 32'h0); #1;
      chk("t3_g0", 32'(gnt[1]), 32'h1); chk("t3_v0", 32'(rvalid[1]), 32'h0);
      tick; drive(1, 1'b1, 32'h4000_0008, 1'b0, 4'h0, 32'h0); #1;
      chk("t3_g1", 32'(gnt[1]), 32'h1); chk("t3_v1", 32'(rvalid[1]), 32'h0);
      tick; drive(1, 1'b1, 32'h4000_000C, 1'b0, 4'h0, 32'h0); #1;
      chk("t3_g2", 32'(gnt[1]), 32'h0); chk("t3_v2", 32'(rvalid[1]), 32'h0);
      chk("t3_en2", 32'(en[1]), 32'h0);
      tick; #1;
      chk("t3_g3", 32'(gnt[1]), 32'h1); chk("t3_v3", 32'(rvalid[1]), 32'h1);
      chk("t3_d3", rdata[1], 32'h1111_0001);
      tick; drive(1, 1'b1, 32'h4000_0010, 1'b0, 4'h0, 32'h0); #1;
      chk("t3_g4", 32'(gnt[1]), 32'h1); chk("t3_v4", 32'(rvalid[1]), 32'h1);
      chk("t3_d4", rdata[1], 32'hAAAA_AAAA);
      tick; drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0); #1;
      chk("t3_v5", 32'(rvalid[1]), 32'h0);
      tick; #1;
      chk("t3_v6", 32'(rvalid[1]), 32'h1); chk("t3_d6", rdata[1], 32'h1111_0003);
      tick; #1;
      chk("t3_v7", 32'(rvalid[1]), 32'h1); chk("t3_d7", rdata[1], 32'hDEAD_BEEF);

      // out-of-window errors between valid reads
      tick; drive(1, 1'b1, 32'h4000_0008, 1'b0, 4'h0, 32'h0); #1;
      chk("t4_g0", 32'(gnt[1]), 32'h1); chk("t4_en0", 32'(en[1]), 32'h1);
      tick; drive(1, 1'b1, 32'h4000_4000, 1'b0, 4'h0, 32'h0); #1;
      chk("t4_g1", 32'(gnt[1]), 32'h1); chk("t4_en1", 32'(en[1]), 32'h0);
      tick; drive(1, 1'b1, 32'h3FFF_FFFC, 1'b0, 4'h0, 32'h0); #1;
      chk("t4_g2", 32'(gnt[1]), 32'h0);
      tick; #1;
      chk("t4_g3", 32'(gnt[1]), 32'h1); chk("t4_en3", 32'(en[1]), 32'h0);
      chk("t4_v3", 32'(rvalid[1]), 32'h1); chk("t4_e3", 32'(err[1]), 32'h0);
      chk("t4_d3", rdata[1], 32'hAAAA_AAAA);
      tick; drive(1, 1'b1, 32'h4000_000C, 1'b0, 4'h0, 32'h0); #1;
      chk("t4_g4", 32'(gnt[1]), 32'h1); chk("t4_en4", 32'(en[1]), 32'h1);
      chk("t4_v4", 32'(rvalid[1]), 32'h1); chk("t4_e4", 32'(err[1]), 32'h1);
      chk("t4_d4", rdata[1], 32'h0);
      tick; drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0); #1;
      chk("t4_v5", 32'(rvalid[1]), 32'h0);
      tick; #1;
      chk("t4_v6", 32'(rvalid[1]), 32'h1); chk("t4_e6", 32'(err[1]), 32'h1);
      chk("t4_d6", rdata[1], 32'h0);
      tick; #1;
      chk("t4_v7", 32'(rvalid[1]), 32'h1); chk("t4_e7", 32'(err[1]), 32'h0);
      chk("t4_d7", rdata[1], 32'h1111_0003);

      // reset with three reads in flight at latency 4
      tick; drive(2, 1'b1, 32'h14, 1'b0, 4'h0, 32'h0); #1;
      chk("t5_g0", 32'(gnt[2]), 32'h1);
      tick; drive(2, 1'b1, 32'h18, 1'b0, 4'h0, 32'h0); #1;
      chk("t5_g1", 32'(gnt[2]), 32'h1);
      tick; drive(2, 1'b1, 32'h1C, 1'b0, 4'h0, 32'h0); #1;
      chk("t5_g2", 32'(gnt[2]), 32'h1);
      tick; drive(2, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0); #1;
      chk("t5_g3", 32'(gnt[2]), 32'h0); chk("t5_v3", 32'(rvalid[2]), 32'h0);
      tick; #1;
      chk("t5_v4", 32'(rvalid[2]), 32'h1); chk("t5_d4", rdata[2], 32'h1111_0005);
      chk("t5_g4", 32'(gnt[2]), 32'h1);
      rst = 1'b1; #1;
      chk("t5_rst_g", 32'(gnt[2]),    32'h0);
      chk("t5_rst_v", 32'(rvalid[2]), 32'h0);
      chk("t5_rst_d", rdata[2],       32'h0);
      tick;
      rst = 1'b0;
      drive(2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0); #1;
      chk("t5_stale0", 32'(rvalid[2]), 32'h0);
      for (int k = 1; k < 5; k++) begin
         tick;
         chk($sformatf("t5_stale%0d", k), 32'(rvalid[2]), 32'h0);
      end
      tick; drive(2, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0); #1;
      chk("t5_n0", 32'(gnt[2]), 32'h1);
      tick; drive(2, 1'b1, 32'h24, 1'b0, 4'h0, 32'h0); #1;
      chk("t5_n1", 32'(gnt[2]), 32'h1);
      tick; drive(2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0); #1;
      chk("t5_nv2", 32'(rvalid[2]), 32'h0);
      tick; #1;
      chk("t5_nv3", 32'(rvalid[2]), 32'h0);
      tick; #1;
      chk("t5_nv4", 32'(rvalid[2]), 32'h1); chk("t5_nd4", rdata[2], 32'h1111_0008);
      tick; #1;
      chk("t5_nv5", 32'(rvalid[2]), 32'h1); chk("t5_nd5", rdata[2], 32'h1111_0009);

      // registered outputs, latency 2 + 1, sustained one request per cycle
      for (int k = 0; k < 5; k++) begin
         tick; drive(3, 1'b1, 32'(4 * (10 + k)), 1'b0, 4'h0, 32'h0); #1;
         chk($sformatf("t6_g%0d", k), 32'(gnt[3]), 32'h1);
         chk($sformatf("t6_v%0d", k), 32'(rvalid[3]), (k >= 3) ? 32'h1 : 32'h0);
         if (k >= 3) chk($sformatf("t6_d%0d", k), rdata[3], 32'h1111_0000 + 32'(10 + k - 3));
      end
      tick; drive(3, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0); #1;
      chk("t6_v5", 32'(rvalid[3]), 32'h1); chk("t6_d5", rdata[3], 32'h1111_000C);
      tick; #1;
      chk("t6_v6", 32'(rvalid[3]), 32'h1); chk("t6_d6", rdata[3], 32'h1111_000D);
      tick; #1;
      chk("t6_v7", 32'(rvalid[3]), 32'h1); chk("t6_d7", rdata[3], 32'h1111_000E);
      chk("t6_e7", 32'(err[3]), 32'h0);
      tick; #1;
      chk("t6_v8", 32'(rvalid[3]), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/coredata_bram_bridge.md
Name: coredata_bram_bridge

Overview:
- Pipelined adapter between a core's req/gnt/rvalid data port and a single-port byte-writable BRAM.
- Supports a configurable BRAM read latency and in-order responses for reads and writes.
- Limits the number of outstanding requests and returns an error response for addresses outside the BRAM window.
- Sits between the core data port and the BRAM controller port in the Zynq system, replacing the fixed 1-cycle adapter.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 32, core byte-address width.
- BRAM_AW, 12, BRAM word-address width; window size is 2^BRAM_AW words.
- BASE_ADDR, 32'h0000_0000, byte address of BRAM word 0; aligned to the window size.
- RD_LATENCY, 1, cycles from BRAM enable to valid bram_din; legal range 1..8.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal range 1..RD_LATENCY+1.
- REG_OUT, 0, 1 = register rvalid_o/rdata_o/err_o (adds 1 cycle).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_i  in  1  core request
- gnt_o  out  1  request accepted this cycle
- addr_i  in  ADDR_WIDTH  byte address
- we_i  in  1  1 = write
- be_i  in  DATA_WIDTH/8  byte enables
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid, one cycle per accepted request
- rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors
- err_o  out  1  response is an out-of-window error; qualified by rvalid_o
- bram_en  out  1  BRAM enable
- bram_we  out  DATA_WIDTH/8  byte write enables
- bram_addr  out  BRAM_AW  word address
- bram_dout  out  DATA_WIDTH  write data to BRAM
- bram_din  in  DATA_WIDTH  read data from BRAM

Interface decision: one clock domain, clk_i; rst_i is asynchronous, active-high.

Behaviour:
- Reset (rst_i=1, asynchronous): clear the token pipeline, outstanding count and output registers.
  - gnt_o, rvalid_o, err_o and bram_en are 0; bram_we is 0; rdata_o is 0.
  - Requests in flight at reset are dropped and produce no response.
- Acceptance: gnt_o = req_i & ~rst_i & (outstanding < MAX_OUTSTANDING), evaluated combinationally in the same cycle. A request is accepted when req_i & gnt_o.
- Address decode: in_window = ((addr_i - BASE_ADDR) >> log2(DATA_WIDTH/8)) < 2^BRAM_AW, with unsigned subtraction; addresses below BASE_ADDR wrap and fail the check.
  - bram_addr = low BRAM_AW bits of that word offset.
  - Misaligned low address bits are ignored.
- BRAM drive, in the acceptance cycle only, and only when in_window:
  - bram_en = 1.
  - bram_we = we_i ? be_i : 0.
  - bram_dout = wdata_i.
  - Out-of-window accesses never touch the BRAM: bram_en = 0 and bram_we = 0.
- Token pipeline:
  - Each accepted request pushes a token {valid, is_read, err} into a shift register RD_LATENCY stages deep. It advances every cycle and never stalls.
  - When the token exits stage RD_LATENCY: rvalid_o = 1; err_o = token.err; rdata_o = (is_read & ~err) ? bram_din : 0.
  - Response latency is RD_LATENCY cycles after acceptance, or RD_LATENCY+1 when REG_OUT=1. Writes and errors take the same latency, so responses stay in order.
- Outstanding counter:
  - Increment on acceptance; decrement on response (the rvalid_o cycle, counted after the REG_OUT stage).
  - Simultaneous accept and response: count unchanged.
  - The counter never exceeds MAX_OUTSTANDING and never underflows.
- Back-to-back: with MAX_OUTSTANDING ≥ RD_LATENCY (or ≥ RD_LATENCY+1 when REG_OUT=1), throughput is one request per cycle. Below that, gnt_o drops while the count is at the limit.
- No response backpressure: the core must accept rvalid_o whenever it is asserted.
- A read following a write to the same address returns the new data; this relies on the BRAM's write-first or sequential access.

Test Plan:
- RD_LATENCY=1, single read of 0x10 (BRAM word 4 = 32'hDEAD_BEEF) -> gnt_o=1 in cycle 0; bram_en=1, bram_addr=4; rvalid_o=1 with rdata_o=32'hDEAD_BEEF in cycle 1; err_o=0.
- Write 0x8, be=4'b0011, wdata=32'h1234_5678, then read 0x8 (prior word 32'hAAAA_AAAA) -> bram_we=4'b0011 in the write cycle; write response has rdata_o=0; read returns 32'hAAAA_5678.
- RD_LATENCY=3, MAX_OUTSTANDING=2, req_i held for 4 reads -> gnt_o pattern 1,1,0,1,…; rvalid_o pattern 0,0,0,1,1,0,1…; data returned in issue order.
- BASE_ADDR=32'h4000_0000, BRAM_AW=12, read 0x4000_4000 and 0x3FFF_FFFC -> bram_en stays 0; two responses with err_o=1, rdata_o=0, in order with neighbouring valid reads.
- Reset asserted mid-flight with RD_LATENCY=4 and 3 requests outstanding -> gnt_o/rvalid_o drop immediately; no stale rvalid_o after release; the count restarts at 0, so 2 new requests are granted at once.
- REG_OUT=1, RD_LATENCY=2, back-to-back reads with MAX_OUTSTANDING=3 -> each response arrives at 3-cycle latency; sustained 1 request/cycle with gnt_o held at 1.
